interval_timing_monitor: RTL and testbench
==========================================

Name: interval_timing_monitor

Overview:
- Synthesisable, multi-channel cycle-accurate interval checker; parametrised successor to the behavioural posedge-to-posedge max-delay check.
- Per channel: measures clock cycles from a rising edge on start to a rising edge on stop, checks the interval against runtime min/max limits and flags violations with sticky flags.
- Also reports each measurement, signals timeouts and keeps a saturating global violation count.
- Sits beside PCS/PMA blocks in simulation and hardware to police state-machine timer intervals.

Parameters:
CHANNELS, 4, number of independent channels (1..32)
CNT_WIDTH, 16, width of interval counter, limits and measured value
ERR_WIDTH, 8, width of global violation counter

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
enable  input  CHANNELS  per-channel enable; low forces channel IDLE
start  input  CHANNELS  start events, synchronous to clock; event = sampled 0->1 transition
stop  input  CHANNELS  stop events, synchronous to clock; event = sampled 0->1 transition
min_limit  input  CNT_WIDTH  minimum legal interval; 0 = check disabled
max_limit  input  CNT_WIDTH  maximum legal interval; 0 = check disabled
clear_err  input  1  synchronous clear of all sticky flags and error_count
busy  output  CHANNELS  channel in TIMING
meas_valid  output  CHANNELS  one-cycle pulse: new measurement on meas_value
meas_value  output  CHANNELS*CNT_WIDTH  last measured interval, channel i in bits [i*CNT_WIDTH +: CNT_WIDTH]
min_err  output  CHANNELS  sticky: interval < min_limit seen
max_err  output  CHANNELS  sticky: timeout (interval exceeded max_limit) seen
timeout  output  CHANNELS  one-cycle pulse on timeout
error_count  output  ERR_WIDTH  saturating count of violation events, all channels

Behaviour:
- Reset (reset_n low, asynchronous): every output 0, all counters 0, all channels IDLE, edge-detect history registers 0.
- Edge detect: a previous-value register per input; an event is current = 1 and previous = 0. History updates every clock, even when the channel is disabled, so no false edge occurs on enable.
- Per-channel FSM with states IDLE and TIMING.
  - IDLE, start event: go to TIMING; count <= 1.
  - IDLE, stop event alone: ignored.
  - TIMING, no event: count <= count + 1, saturating at all-ones.
  - TIMING, stop event: meas_value <= count and meas_valid = 1 in the next cycle. Set min_err if min_limit != 0 and count < min_limit. Go to IDLE.
  - TIMING, start and stop events in the same cycle: complete the measurement as above, then restart; stay in TIMING with count <= 1.
  - TIMING, start event without stop: restart; count <= 1; no measurement.
- Resulting interval: start sampled at clock edge c, stop sampled at edge c+d gives meas_value = d.
- Timeout: in TIMING with max_limit != 0, count == max_limit and no stop event that cycle.
  - Set max_err; pulse timeout for one cycle; go to IDLE.
  - No meas_valid is produced.
  - A stop at d = max_limit is legal.
- max_limit = 0: no timeout. The count saturates; a stop then reports all-ones.
- max_limit changed mid-interval: count > max_limit never times out.
- enable[i] low: channel goes IDLE next clock. Count, pending measurement and outputs busy, meas_valid and timeout are forced low. Sticky flags and meas_value hold.
- error_count adds the popcount of new violations (min_err set events plus timeout events) each cycle, saturating at all-ones. Re-flagging an already sticky flag still counts.
- clear_err: clears min_err, max_err and error_count. A new violation in the same cycle wins: its flag is set and error_count = that cycle's increment.
- Outputs are registered. meas_valid, timeout and busy reflect the state after the clock edge that processed the events.

Test Plan:
- Reset mid-TIMING on ch0 (count = 5) -> all outputs 0 immediately; a subsequent stop produces no meas_valid.
- ch0, min=3, max=10; start at edge 0, stop at edge 7 -> meas_value[0] = 7 with one meas_valid pulse; min_err and max_err stay 0; error_count = 0.
- ch1, min=3; start then stop 2 cycles later -> meas_value = 2, min_err[1] = 1, error_count = 1. clear_err -> flags 0, error_count 0.
- ch2, max=4, no stop -> timeout pulse at edge 4 after start, max_err[2] = 1, busy low, no meas_valid. A stop exactly at d = 4 in a rerun -> meas_value = 4 and no error.
- ch3 in TIMING, start and stop in the same cycle at d = 6 -> meas_value = 6; busy stays 1; a next stop 3 cycles later reports 3.
- All 4 channels time out in the same cycle with ERR_WIDTH = 2 and error_count = 2 -> error_count saturates at 3. Simultaneous clear_err with one new violation -> error_count = 1.

Source files
------------

// File: rtl/interval_timing_monitor.sv
// Multi-channel start-to-stop interval checker with runtime min/max limits,
// sticky violation flags, timeout pulses and a saturating global error count.
//
// state  | meaning
// IDLE   | waiting for a start event
// TIMING | counting cycles since the last start event
module interval_timing_monitor #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 16,
  parameter int ERR_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [CHANNELS-1:0]           enable,
  input  logic [CHANNELS-1:0]           start,
  input  logic [CHANNELS-1:0]           stop,
  input  logic [CNT_WIDTH-1:0]          min_limit,
  input  logic [CNT_WIDTH-1:0]          max_limit,
  input  logic                          clear_err,
  output logic [CHANNELS-1:0]           busy,
  output logic [CHANNELS-1:0]           meas_valid,
  output logic [CHANNELS*CNT_WIDTH-1:0] meas_value,
  output logic [CHANNELS-1:0]           min_err,
  output logic [CHANNELS-1:0]           max_err,
  output logic [CHANNELS-1:0]           timeout,
  output logic [ERR_WIDTH-1:0]          error_count
);

  typedef enum logic {IDLE = 1'b0, TIMING = 1'b1} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam int SUM_W = ERR_WIDTH + 7;
  localparam logic [SUM_W-1:0] ERR_MAX = {{7{1'b0}}, {ERR_WIDTH{1'b1}}};

  logic [CHANNELS-1:0] start_prev_q, stop_prev_q;
  logic [CHANNELS-1:0] min_set, tout_set;
  logic [CHANNELS-1:0] min_err_q, min_err_d, max_err_q, max_err_d;
  logic [ERR_WIDTH-1:0] err_cnt_q, err_cnt_d;

  // History registers run regardless of enable so enabling never fakes an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_prev_q <= '0;
      stop_prev_q  <= '0;
    end else begin
      start_prev_q <= start;
      stop_prev_q  <= stop;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] meas_q, meas_d;
    logic                 valid_q, valid_d;
    logic                 tout_q, tout_d;
    logic                 min_viol;
    logic                 start_ev, stop_ev;

    assign start_ev = start[g] & ~start_prev_q[g];
    assign stop_ev  = stop[g] & ~stop_prev_q[g];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        count_q <= '0;
        meas_q  <= '0;
        valid_q <= 1'b0;
        tout_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
        meas_q  <= meas_d;
        valid_q <= valid_d;
        tout_q  <= tout_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      meas_d   = meas_q;
      valid_d  = 1'b0;
      tout_d   = 1'b0;
      min_viol = 1'b0;
      if (!enable[g]) begin
        state_d = IDLE;
        count_d = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_ev) begin
              state_d = TIMING;
              count_d = CNT_ONE;
            end
          end
          TIMING: begin
            if (stop_ev) begin
              meas_d   = count_q;
              valid_d  = 1'b1;
              min_viol = (min_limit != '0) && (count_q < min_limit);
              if (start_ev) begin
                count_d = CNT_ONE;
              end else begin
                state_d = IDLE;
                count_d = '0;
              end
            end else if ((max_limit != '0) && (count_q == max_limit)) begin
              // Equality only: lowering max_limit below a running count never fires.
              tout_d  = 1'b1;
              state_d = IDLE;
              count_d = '0;
            end else if (start_ev) begin
              count_d = CNT_ONE;
            end else if (count_q != '1) begin
              count_d = count_q + CNT_ONE;
            end
          end
          default: begin
            state_d = IDLE;
            count_d = '0;
          end
        endcase
      end
    end

    assign min_set[g]                              = min_viol;
    assign tout_set[g]                             = tout_d;
    assign busy[g]                                 = (state_q == TIMING);
    assign meas_valid[g]                           = valid_q;
    assign timeout[g]                              = tout_q;
    assign meas_value[g*CNT_WIDTH +: CNT_WIDTH]    = meas_q;
  end

  logic [SUM_W-1:0] err_inc, err_base, err_sum;

  always_comb begin
    err_inc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      err_inc = err_inc + SUM_W'(min_set[i]) + SUM_W'(tout_set[i]);
    end
    err_base  = clear_err ? '0 : SUM_W'(err_cnt_q);
    err_sum   = err_base + err_inc;
    err_cnt_d = (err_sum > ERR_MAX) ? {ERR_WIDTH{1'b1}} : err_sum[ERR_WIDTH-1:0];
    min_err_d = (clear_err ? '0 : min_err_q) | min_set;
    max_err_d = (clear_err ? '0 : max_err_q) | tout_set;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      min_err_q <= '0;
      max_err_q <= '0;
      err_cnt_q <= '0;
    end else begin
      min_err_q <= min_err_d;
      max_err_q <= max_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign min_err     = min_err_q;
  assign max_err     = max_err_q;
  assign error_count = err_cnt_q;

endmodule

// File: tb/tb_interval_timing_monitor.sv
// Directed bench for interval_timing_monitor (4 channels, 16-bit counts,
// 2-bit error counter so saturation is reachable).
module tb_interval_timing_monitor;

  localparam int CH = 4;
  localparam int CW = 16;
  localparam int EW = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [CH-1:0] enable, start, stop;
  logic [CW-1:0] min_limit, max_limit;
  logic          clear_err;
  logic [CH-1:0] busy, meas_valid, min_err, max_err, timeout;
  logic [CH*CW-1:0] meas_value;
  logic [EW-1:0] error_count;

  int n_tests = 0;
  int n_fail  = 0;

  interval_timing_monitor #(.CHANNELS(CH), .CNT_WIDTH(CW), .ERR_WIDTH(EW)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .start(start), .stop(stop),
    .min_limit(min_limit), .max_limit(max_limit), .clear_err(clear_err),
    .busy(busy), .meas_valid(meas_valid), .meas_value(meas_value),
    .min_err(min_err), .max_err(max_err), .timeout(timeout), .error_count(error_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [CW-1:0] mv(input int ch);
    return meas_value[ch*CW +: CW];
  endfunction

  initial begin
    reset_n = 1'b0; enable = '0; start = '0; stop = '0;
    min_limit = '0; max_limit = '0; clear_err = 1'b0;
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_meas", meas_value, 0);
    check("rst_errcnt", error_count, 0);
    reset_n = 1'b1; enable = '1;
    tick();

    // reset while ch0 is timing
    start = 4'b0001; tick(); start = '0;
    tick(4);
    check("pre_rst_busy", busy, 4'b0001);
    reset_n = 1'b0; #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", meas_valid, 0);
    reset_n = 1'b1; tick();
    stop = 4'b0001; tick(); stop = '0;
    check("rst_stop_novalid", meas_valid, 0);
    tick();
    check("rst_stop_novalid2", meas_valid, 0);

    // ch0 legal interval of 7
    min_limit = 3; max_limit = 10;
    start = 4'b0001; tick(); start = '0;
    check("c0_busy", busy, 4'b0001);
    tick(6);
    stop = 4'b0001; tick(); stop = '0;
    check("c0_meas", mv(0), 7);
    check("c0_valid", meas_valid, 4'b0001);
    check("c0_busy_off", busy, 0);
    tick();
    check("c0_valid_pulse", meas_valid, 0);
    check("c0_minerr", min_err, 0);
    check("c0_maxerr", max_err, 0);
    check("c0_errcnt", error_count, 0);

    // ch1 too short
    max_limit = 0;
    start = 4'b0010; tick(); start = '0;
    tick();
    stop = 4'b0010; tick(); stop = '0;
    check("c1_meas", mv(1), 2);
    check("c1_valid", meas_valid, 4'b0010);
    check("c1_minerr", min_err, 4'b0010);
    check("c1_errcnt", error_count, 1);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    check("c1_clr_minerr", min_err, 0);
    check("c1_clr_errcnt", error_count, 0);

    // ch2 timeout at 4, then legal stop at exactly 4
    min_limit = 0; max_limit = 4;
    start = 4'b0100; tick(); start = '0;
    tick(3);
    check("c2_no_tout_yet", timeout, 0);
    check("c2_busy", busy, 4'b0100);
    tick();
    check("c2_tout", timeout, 4'b0100);
    check("c2_maxerr", max_err, 4'b0100);
    check("c2_busy_off", busy, 0);
    check("c2_novalid", meas_valid, 0);
    check("c2_errcnt", error_count, 1);
    tick();
    check("c2_tout_pulse", timeout, 0);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    start = 4'b0100; tick(); start = '0;
    tick(3);
    stop = 4'b0100; tick(); stop = '0;
    check("c2_meas4", mv(2), 4);
    check("c2_valid4", meas_valid, 4'b0100);
    check("c2_tout4", timeout, 0);
    check("c2_maxerr4", max_err, 0);
    check("c2_errcnt4", error_count, 0);
    tick();

    // ch3 start+stop together restarts the interval
    max_limit = 0;
    start = 4'b1000; tick(); start = '0;
    tick(5);
    start = 4'b1000; stop = 4'b1000; tick(); start = '0; stop = '0;
    check("c3_meas6", mv(3), 6);
    check("c3_valid6", meas_valid, 4'b1000);
    check("c3_busy", busy, 4'b1000);
    tick(2);
    stop = 4'b1000; tick(); stop = '0;
    check("c3_meas3", mv(3), 3);
    check("c3_idle", busy, 0);
    tick();

    // enable low aborts a channel
    start = 4'b0001; tick(); start = '0;
    enable = 4'b1110; tick();
    check("en_busy_off", busy, 0);
    enable = '1;
    stop = 4'b0001; tick(); stop = '0;
    check("en_novalid", meas_valid, 0);
    check("en_meas_hold", mv(0), 7);
    tick();

    // error counter saturation and clear-vs-new-violation
    min_limit = 3; max_limit = 0;
    start = 4'b0011; tick(); start = '0;
    stop = 4'b0011; tick(); stop = '0;
    check("sat_minerr", min_err, 4'b0011);
    check("sat_errcnt2", error_count, 2);
    tick();
    min_limit = 0; max_limit = 2;
    start = 4'b1111; tick(); start = '0;
    tick();
    check("sat_pre", timeout, 0);
    tick();
    check("sat_tout_all", timeout, 4'b1111);
    check("sat_maxerr_all", max_err, 4'b1111);
    check("sat_errcnt3", error_count, 3);
    start = 4'b0001; tick(); start = '0;
    tick();
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    check("clr_win_tout", timeout, 4'b0001);
    check("clr_win_maxerr", max_err, 4'b0001);
    check("clr_win_minerr", min_err, 0);
    check("clr_win_errcnt", error_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
